mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 62 ++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cpu/gpu/display request ports plus the single-port RAM side of mem_arbiter.
interface mem_arbiter_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [11:0] cpu_idx;
    logic [7:0]  cpu_write_byte;
    logic        cpu_ack;
    logic        gpu_read;
    logic        gpu_write;
    logic [11:0] gpu_idx;
    logic [7:0]  gpu_write_byte;
    logic        gpu_ack;
    logic        disp_read;
    logic [11:0] disp_idx;
    logic        disp_ack;
    logic [7:0]  read_byte;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_idx, cpu_write_byte,
        input  gpu_read, gpu_write, gpu_idx, gpu_write_byte,
        input  disp_read, disp_idx, ram_rdata,
        output cpu_ack, gpu_ack, disp_ack, read_byte, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_idx, cpu_write_byte,
        output gpu_read, gpu_write, gpu_idx, gpu_write_byte,
        output disp_read, disp_idx, ram_rdata,
        input  cpu_ack, gpu_ack, disp_ack, read_byte, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-grant-per-cycle arbiter of cpu/gpu/display onto a synchronous single-port RAM.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] G_NONE = 2'd0, G_CPU = 2'd1, G_GPU = 2'd2, G_DISP = 2'd3;
    logic [1:0]    w_grant;
    logic [1:0]    w_rr;
    logic          w_cpu_req, w_gpu_req, w_cpu_starved, w_gpu_starved;
    logic          r_ptr;
    logic [CW-1:0] r_cpu_wait, r_gpu_wait;
    logic          r_cpu_ack, r_gpu_ack, r_disp_ack;

    function automatic logic [CW-1:0] next_wait(input logic req, input logic granted, input logic [CW-1:0] w);
        return (req && !granted) ? ((w == CW'(STARVE_LIMIT)) ? w : w + 1'b1) : '0;
    endfunction

    assign w_cpu_req     = bus.cpu_read | bus.cpu_write;
    assign w_gpu_req     = bus.gpu_read | bus.gpu_write;
    assign w_cpu_starved = w_cpu_req && (r_cpu_wait == CW'(STARVE_LIMIT));
    assign w_gpu_starved = w_gpu_req && (r_gpu_wait == CW'(STARVE_LIMIT));

    // r_ptr = 0 prefers cpu; starved ports outrank display, display outranks plain cpu/gpu
    always_comb begin
        w_rr    = (w_cpu_req && w_gpu_req) ? (r_ptr ? G_GPU : G_CPU) : w_cpu_req ? G_CPU : w_gpu_req ? G_GPU : G_NONE;
        w_grant = reset ? G_NONE :
                  (w_cpu_starved && w_gpu_starved) ? (r_ptr ? G_GPU : G_CPU) :
                  w_cpu_starved ? G_CPU : w_gpu_starved ? G_GPU :
                  bus.disp_read ? G_DISP : w_rr;
    end

    assign bus.ram_addr  = (w_grant == G_CPU) ? bus.cpu_idx : (w_grant == G_GPU) ? bus.gpu_idx :
                           (w_grant == G_DISP) ? bus.disp_idx : '0;
    assign bus.ram_we    = ((w_grant == G_CPU) && bus.cpu_write) || ((w_grant == G_GPU) && bus.gpu_write);
    assign bus.ram_wdata = (w_grant == G_CPU) ? bus.cpu_write_byte : (w_grant == G_GPU) ? bus.gpu_write_byte : '0;
    assign bus.read_byte = bus.ram_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.gpu_ack   = r_gpu_ack;
    assign bus.disp_ack  = r_disp_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= 1'b0;
            r_cpu_wait <= '0;
            r_gpu_wait <= '0;
            r_cpu_ack  <= 1'b0;
            r_gpu_ack  <= 1'b0;
            r_disp_ack <= 1'b0;
        end else begin
            r_cpu_ack  <= w_grant == G_CPU;
            r_gpu_ack  <= w_grant == G_GPU;
            r_disp_ack <= w_grant == G_DISP;
            r_cpu_wait <= next_wait(w_cpu_req, w_grant == G_CPU, r_cpu_wait);
            r_gpu_wait <= next_wait(w_gpu_req, w_grant == G_GPU, r_gpu_wait);
            r_ptr      <= (w_grant == G_CPU) ? 1'b1 : (w_grant == G_GPU) ? 1'b0 : r_ptr;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; a priority-score reference model predicts grants, RAM bus and acks.
module tb_mem_arbiter;
    localparam int LIM = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] ram [4096];
    logic [7:0] ref_mem [4096];

    function automatic logic [7:0] pat(input int i);
        return (i == 'h200) ? 8'hA5 : 8'(i * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
        end else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    typedef struct {
        int         cyc;
        logic [2:0] ack;
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, cyc = 0;
    int cw = 0, gw = 0, last_g = 0;
    bit pref_gpu = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Highest score wins: starved +20, display 11, round-robin preference +1
    task automatic step();
        int sc [4];
        int g;
        bit cr, gr, we;
        logic [11:0] a;
        logic [7:0] d;
        exp_t e;
        #1;
        cr = bus.cpu_read || bus.cpu_write;
        gr = bus.gpu_read || bus.gpu_write;
        sc[0] = 0;
        sc[1] = cr ? 1 + (pref_gpu ? 0 : 1) + (cw == LIM ? 20 : 0) : 0;
        sc[2] = gr ? 1 + (pref_gpu ? 1 : 0) + (gw == LIM ? 20 : 0) : 0;
        sc[3] = bus.disp_read ? 11 : 0;
        g = 0;
        for (int p = 1; p < 4; p++) if (sc[p] > sc[g]) g = p;
        if (reset) g = 0;
        a  = g == 1 ? bus.cpu_idx : g == 2 ? bus.gpu_idx : g == 3 ? bus.disp_idx : 12'h0;
        we = (g == 1 && bus.cpu_write) || (g == 2 && bus.gpu_write);
        d  = g == 1 ? bus.cpu_write_byte : g == 2 ? bus.gpu_write_byte : 8'h0;
        check("ram_addr", 32'(bus.ram_addr), 32'(a));
        check("ram_we", 32'(bus.ram_we), 32'(we));
        check("ram_wdata", 32'(bus.ram_wdata), 32'(d));
        if (g != 0) begin
            e.cyc = cyc + 1;
            e.ack = 3'(4 >> (g - 1));
            e.rd = !we;
            e.data = ref_mem[a];
            q.push_back(e);
        end
        if (we) ref_mem[a] = d;
        cw = (cr && g != 1 && !reset) ? (cw < LIM ? cw + 1 : LIM) : 0;
        gw = (gr && g != 2 && !reset) ? (gw < LIM ? gw + 1 : LIM) : 0;
        pref_gpu = reset ? 1'b0 : g == 1 ? 1'b1 : g == 2 ? 1'b0 : pref_gpu;
        last_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.cpu_read = 0; bus.cpu_write = 0; bus.gpu_read = 0; bus.gpu_write = 0; bus.disp_read = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [2:0] acks;
        forever begin
            @(posedge clk);
            #1;
            acks = {bus.cpu_ack, bus.gpu_ack, bus.disp_ack};
            if (acks != 3'b000 || (q.size() > 0 && q[0].cyc <= cyc)) begin
                if (q.size() == 0) check("unexpected_ack", 32'(acks), 32'h0);
                else begin
                    e = q.pop_front();
                    check("ack_port", 32'(acks), 32'(e.ack));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.rd) check("read_byte", 32'(bus.read_byte), 32'(e.data));
                end
            end
        end
    end

    initial begin
        logic [1:0] r;
        int dp;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        idle();
        bus.cpu_idx = 0; bus.cpu_write_byte = 0; bus.gpu_idx = 0; bus.gpu_write_byte = 0; bus.disp_idx = 0;
        @(negedge clk);
        load = 1'b0;
        check("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        check("rst_gpu_ack", 32'(bus.gpu_ack), 0);
        check("rst_disp_ack", 32'(bus.disp_ack), 0);
        bus.gpu_write = 1; bus.gpu_idx = 12'h010; bus.gpu_write_byte = 8'hEE;
        step();
        reset = 1'b0;
        idle();
        step();
        // single cpu read of preloaded byte
        bus.cpu_read = 1; bus.cpu_idx = 12'h200;
        step();
        idle();
        step(); step();
        // cpu and gpu writes alternate from a fresh reset
        pulse_reset();
        bus.cpu_write = 1; bus.cpu_idx = 12'h011; bus.cpu_write_byte = 8'h11;
        bus.gpu_write = 1; bus.gpu_idx = 12'h022; bus.gpu_write_byte = 8'h22;
        repeat (6) step();
        idle();
        step();
        // display hogging until cpu starves
        pulse_reset();
        bus.disp_read = 1; bus.disp_idx = 12'h080;
        bus.cpu_read = 1; bus.cpu_idx = 12'h200;
        repeat (12) step();
        idle();
        step();
        // gpu write then immediate read-back
        bus.gpu_write = 1; bus.gpu_idx = 12'h105; bus.gpu_write_byte = 8'h3C;
        step();
        bus.gpu_write = 0; bus.gpu_read = 1;
        step();
        idle();
        step(); step();
        // read+write together is a write
        bus.cpu_read = 1; bus.cpu_write = 1; bus.cpu_idx = 12'h300; bus.cpu_write_byte = 8'h7E;
        step();
        idle();
        bus.gpu_read = 1; bus.gpu_idx = 12'h300;
        step();
        idle();
        step(); step();
        // reset lands on a gpu write grant cycle
        bus.gpu_write = 1; bus.gpu_idx = 12'h400; bus.gpu_write_byte = 8'h99;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        step();
        bus.cpu_read = 1; bus.cpu_idx = 12'h400;
        bus.gpu_read = 1; bus.gpu_idx = 12'h400;
        step(); step();
        idle();
        step(); step();
        // randomized traffic with alternating light/heavy display load
        for (int i = 0; i < 3000; i++) begin
            dp = ((i / 300) % 2 == 1) ? 95 : 25;
            if (last_g == 1 || !(bus.cpu_read || bus.cpu_write)) begin
                r = 2'($urandom);
                bus.cpu_read = r[0]; bus.cpu_write = r[1];
                bus.cpu_idx = 12'($urandom_range(0, 63)); bus.cpu_write_byte = 8'($urandom);
            end
            if (last_g == 2 || !(bus.gpu_read || bus.gpu_write)) begin
                r = 2'($urandom);
                bus.gpu_read = r[0]; bus.gpu_write = r[1];
                bus.gpu_idx = 12'($urandom_range(0, 63)); bus.gpu_write_byte = 8'($urandom);
            end
            if (last_g == 3 || !bus.disp_read) begin
                bus.disp_read = $urandom_range(0, 99) < dp;
                bus.disp_idx = 12'($urandom_range(0, 63));
            end
            step();
        end
        idle();
        step(); step(); step();
        check("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
